icache_direct: RTL

Direct-mapped, read-only instruction cache between the core's instruction bus (ibus) and the cache bus (CBus). It replaces the plain ibus-to-CBus conversion on the fetch path, and its CBus request feeds the instruction port of the CBus arbiter. Hits return in the request cycle. Misses refill one full line with a 4-beat incrementing burst. Addresses with bit 31 clear are uncached (MMIO) and bypass the array with a single-beat read.

---
 rtl/icache_direct.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache bridging the ibus fetch port to CBus.
// Hits answer combinationally; misses refill a 32-byte line; addr[31]=0 bypasses.
package icache_pkg;
  typedef logic [2:0] msize_t;
  typedef logic [7:0] mlen_t;
  typedef logic [1:0] axi_burst_type_t;

  localparam msize_t MSIZE1 = 3'd0;
  localparam msize_t MSIZE2 = 3'd1;
  localparam msize_t MSIZE4 = 3'd2;
  localparam msize_t MSIZE8 = 3'd3;

  localparam mlen_t MLEN1  = 8'd0;
  localparam mlen_t MLEN2  = 8'd1;
  localparam mlen_t MLEN4  = 8'd3;
  localparam mlen_t MLEN8  = 8'd7;
  localparam mlen_t MLEN16 = 8'd15;

  localparam axi_burst_type_t AXI_BURST_FIXED = 2'd0;
  localparam axi_burst_type_t AXI_BURST_INCR  = 2'd1;
  localparam axi_burst_type_t AXI_BURST_WRAP  = 2'd2;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic            valid;
    logic            is_write;
    msize_t          size;
    logic [31:0]     addr;
    logic [7:0]      strobe;
    logic [63:0]     data;
    mlen_t           len;
    axi_burst_type_t burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

module icache_direct
  import icache_pkg::*;
#(
  parameter int NSETS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  output cbus_req_t  icreq,
  input  cbus_resp_t icresp,
  input  logic       flush
);
  localparam int IW = $clog2(NSETS);
  localparam int TW = 32 - 5 - IW;

  typedef enum logic [1:0] {IDLE, REFILL, BYPASS, RESP} state_t;

  state_t            state_reg, state_next;
  logic [1:0]        beat_cnt_reg;
  logic              flush_pending_reg;
  logic [NSETS-1:0]  valid_reg;
  logic [31:0]       addr_reg;
  logic [31:0]       resp_data_reg;

  logic [TW-1:0]     tag_mem  [NSETS];
  logic [63:0]       data_mem [NSETS*4];

  logic [IW-1:0]     idx, fill_idx;
  logic [TW-1:0]     tag, fill_tag;
  logic              cacheable, flush_now, hit, start_req;
  logic [63:0]       hit_word;
  logic              unused_addr_bits;

  assign idx       = ireq.addr[5+IW-1:5];
  assign tag       = ireq.addr[31:5+IW];
  assign cacheable = ireq.addr[31];
  assign fill_idx  = addr_reg[5+IW-1:5];
  assign fill_tag  = addr_reg[31:5+IW];
  assign hit_word  = data_mem[{idx, ireq.addr[4:3]}];
  assign unused_addr_bits = ^ireq.addr[1:0];

  // A flush seen in IDLE (fresh or deferred) wins over any hit in that cycle.
  assign flush_now = flush | flush_pending_reg;
  assign hit       = (state_reg == IDLE) && ireq.valid && cacheable &&
                     valid_reg[idx] && (tag_mem[idx] == tag) && !flush_now;
  assign start_req = (state_reg == IDLE) && ireq.valid && !hit;

  always_comb begin
    state_next = state_reg;
    iresp      = '0;
    icreq      = '0;
    case (state_reg)
      IDLE: begin
        if (hit) begin
          iresp.addr_ok = 1'b1;
          iresp.data_ok = 1'b1;
          iresp.data    = ireq.addr[2] ? hit_word[63:32] : hit_word[31:0];
        end else if (ireq.valid) begin
          state_next = cacheable ? REFILL : BYPASS;
        end
      end
      REFILL: begin
        icreq.valid = 1'b1;
        icreq.size  = MSIZE8;
        icreq.addr  = addr_reg;
        icreq.len   = MLEN4;
        icreq.burst = AXI_BURST_INCR;
        if (icresp.ready && icresp.last) state_next = IDLE;
      end
      BYPASS: begin
        icreq.valid = 1'b1;
        icreq.size  = MSIZE4;
        icreq.addr  = addr_reg;
        icreq.len   = MLEN1;
        icreq.burst = AXI_BURST_FIXED;
        if (icresp.ready && icresp.last) state_next = RESP;
      end
      RESP: begin
        iresp.addr_ok = 1'b1;
        iresp.data_ok = 1'b1;
        iresp.data    = resp_data_reg;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg         <= IDLE;
      beat_cnt_reg      <= 2'd0;
      flush_pending_reg <= 1'b0;
      valid_reg         <= '0;
      addr_reg          <= '0;
      resp_data_reg     <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start_req) addr_reg <= cacheable ? {ireq.addr[31:5], 5'b0} : ireq.addr;
          if (flush_now) begin
            valid_reg         <= '0;
            flush_pending_reg <= 1'b0;
          end else if (start_req && cacheable) begin
            // The victim set is about to be overwritten; keep it invalid until complete.
            valid_reg[idx] <= 1'b0;
          end
        end
        REFILL: begin
          if (flush) flush_pending_reg <= 1'b1;
          if (icresp.ready) begin
            beat_cnt_reg <= beat_cnt_reg + 2'd1;
            if (icresp.last) begin
              beat_cnt_reg <= 2'd0;
              if (flush || flush_pending_reg) begin
                valid_reg         <= '0;
                flush_pending_reg <= 1'b0;
              end else if (beat_cnt_reg == 2'd3) begin
                valid_reg[fill_idx] <= 1'b1;
              end
            end
          end
        end
        BYPASS: begin
          if (flush) flush_pending_reg <= 1'b1;
          if (icresp.ready && icresp.last)
            resp_data_reg <= addr_reg[2] ? icresp.data[63:32] : icresp.data[31:0];
        end
        default: begin
          if (flush) flush_pending_reg <= 1'b1;
        end
      endcase
    end
  end

  // Line storage carries no reset; the valid bits alone qualify its contents.
  always_ff @(posedge clk) begin
    if (state_reg == REFILL && icresp.ready) begin
      data_mem[{fill_idx, beat_cnt_reg}] <= icresp.data;
      if (icresp.last) tag_mem[fill_idx] <= fill_tag;
    end
  end
endmodule
